// File: rtl/hybrid_noc_router_output_arbiter.sv
// Per-output-port packet arbiter for the hybrid NoC router.
// Grants one input at a time with round-robin priority and holds the grant for
// a whole packet (wormhole). Granted flits pass through one registered output
// stage that supports simultaneous read and write (full throughput).
module hybrid_noc_router_output_arbiter #(
  parameter int FLIT_WIDTH = 32,
  parameter int INPUTS     = 5,
  parameter int IDX_WIDTH  = $clog2(INPUTS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INPUTS*FLIT_WIDTH-1:0] in_flit,
  input  logic [INPUTS-1:0]            in_valid,
  input  logic [INPUTS-1:0]            in_last,
  output logic [INPUTS-1:0]            in_ready,
  output logic [FLIT_WIDTH-1:0]        out_flit,
  output logic                         out_valid,
  output logic                         out_last,
  input  logic                         out_ready,
  input  logic                         enable,
  output logic [INPUTS-1:0]            grant,
  output logic                         busy
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(INPUTS - 1);

  logic [0:0]           state;
  logic [IDX_WIDTH-1:0] ptr;
  logic [IDX_WIDTH-1:0] g_idx;

  logic [FLIT_WIDTH-1:0] flit_arr [INPUTS];

  logic                  sel_found;
  logic [IDX_WIDTH-1:0]  sel_idx;
  logic [IDX_WIDTH-1:0]  scan;
  logic                  active;
  logic                  can_update;
  logic                  xfer;
  logic                  cur_last;
  logic [FLIT_WIDTH-1:0] cur_flit;

  // Index increment with explicit wrap so non-power-of-two INPUTS stays in range.
  function automatic logic [IDX_WIDTH-1:0] wrap_inc(input logic [IDX_WIDTH-1:0] v);
    return (v == LAST_IDX) ? '0 : v + IDX_WIDTH'(1);
  endfunction

  for (genvar i = 0; i < INPUTS; i++) begin : g_unpack
    assign flit_arr[i] = in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
  end

  // Round-robin pick: first requester scanning ptr, ptr+1, ... with wrap.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan      = ptr;
    for (int k = 0; k < INPUTS; k++) begin
      if (!sel_found && in_valid[scan]) begin
        sel_found = 1'b1;
        sel_idx   = scan;
      end
      scan = wrap_inc(scan);
    end
  end

  assign active     = (state == S_ACTIVE);
  assign can_update = ~out_valid | out_ready;
  assign cur_last   = in_last[g_idx];
  assign cur_flit   = flit_arr[g_idx];
  assign xfer       = active & in_valid[g_idx] & can_update;
  // grant is one-hot while ACTIVE, so masking it yields the single ready bit.
  assign in_ready   = (active & can_update) ? grant : '0;
  assign busy       = active | out_valid;

  // Packet-level FSM: arbitrate in IDLE, hold grant until the last flit moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= '0;
      g_idx <= '0;
      grant <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable && sel_found) begin
            state <= S_ACTIVE;
            g_idx <= sel_idx;
            grant <= INPUTS'(1) << sel_idx;
          end
        end
        default: begin
          if (xfer && cur_last) begin
            state <= S_IDLE;
            grant <= '0;
            ptr   <= wrap_inc(g_idx);
          end
        end
      endcase
    end
  end

  // Output register: load on transfer, otherwise drain when downstream takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_flit  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_last  <= cur_last;
      out_flit  <= cur_flit;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hybrid_noc_router_output_arbiter.sv
// Randomized bench for the output arbiter: packet sources per input, random
// downstream backpressure, enable and reset events, checked every cycle against
// a packet-level reference model.
module tb_hybrid_noc_router_output_arbiter;
  localparam int W = 32;
  localparam int N = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_flit;
  logic [N-1:0]   in_valid, in_last, in_ready, grant;
  logic [W-1:0]   out_flit;
  logic           out_valid, out_last, out_ready, enable, busy;

  hybrid_noc_router_output_arbiter #(.FLIT_WIDTH(W), .INPUTS(N)) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_flit(out_flit),
    .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .enable(enable), .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Upstream packet sources: remaining flits, flit index, packet counter.
  int rem [N];
  int fidx[N];
  int pno [N];

  // Reference model: owner of the output (-1 = idle), priority pointer, output stage.
  int           m_owner;
  int           m_ptr;
  bit           m_ov, m_ol;
  logic [W-1:0] m_of;

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_ov = 0; m_ol = 0; m_of = '0;
    for (int i = 0; i < N; i++) rem[i] = 0;
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input logic [N-1:0] mask, input int vprob, input int sprob,
                      input int orprob, input bit en, input bit do_rst);
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_gnt;
    bit           room;
    int           pick;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (rem[i] == 0 && mask[i] && $urandom_range(0, 99) < sprob) begin
        rem[i]  = $urandom_range(1, 4);
        fidx[i] = 0;
        pno[i]++;
      end
      in_valid[i]        = (rem[i] > 0) && ($urandom_range(0, 99) < vprob);
      in_last[i]         = (rem[i] == 1);
      in_flit[i*W +: W]  = {8'(i), 16'(pno[i]), 8'(fidx[i])};
    end
    out_ready = ($urandom_range(0, 99) < orprob);
    enable    = en;
    rst       = do_rst;
    #1;
    room    = !m_ov || out_ready;
    exp_gnt = (m_owner >= 0) ? N'(1) << m_owner : '0;
    exp_rdy = (m_owner >= 0 && room) ? exp_gnt : '0;
    chk("in_ready",  64'(in_ready),  64'(exp_rdy));
    chk("grant",     64'(grant),     64'(exp_gnt));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("out_last",  64'(out_last),  64'(m_ol));
    chk("out_flit",  64'(out_flit),  64'(m_of));
    chk("busy",      64'(busy),      64'(m_owner >= 0 || m_ov));
    if (do_rst) begin
      model_reset();
    end else if (m_owner < 0) begin
      if (out_ready) m_ov = 0;
      pick = rr_pick(in_valid, m_ptr);
      if (en && pick >= 0) m_owner = pick;
    end else if (in_valid[m_owner] && room) begin
      m_ov = 1;
      m_ol = in_last[m_owner];
      m_of = in_flit[m_owner*W +: W];
      rem[m_owner]--;
      fidx[m_owner]++;
      if (m_ol) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end else if (out_ready) begin
      m_ov = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin rem[i] = 0; fidx[i] = 0; pno[i] = 0; end
    rst = 1'b1; in_valid = '0; in_last = '0; in_flit = '0;
    out_ready = 1'b0; enable = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    // Reset values, then a lone requester on input 2.
    step('0, 100, 0, 100, 1'b1, 1'b1);
    for (int c = 0; c < 12; c++) step(5'b00100, 100, 100, 100, 1'b1, 1'b0);
    // Everyone requesting continuously: round-robin rotation.
    for (int c = 0; c < 60; c++) step(5'b11111, 100, 100, 100, 1'b1, 1'b0);
    // Heavy backpressure with stalling sources.
    for (int c = 0; c < 150; c++) step(5'b11111, 60, 50, 30, 1'b1, 1'b0);
    // Enable toggling, including mid-packet falls and idle-time holds.
    for (int c = 0; c < 200; c++)
      step(5'b11111, 80, 60, 70, ($urandom_range(0, 9) < 6), 1'b0);
    // Reset in the middle of traffic, then traffic again.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 40; c++) step(5'b11111, 85, 70, 60, 1'b1, 1'b0);
      step(5'b11111, 85, 70, 60, 1'b1, 1'b1);
    end
    // Sole requester on input 4 with enable held low, then released.
    for (int c = 0; c < 15; c++) step(5'b10000, 100, 100, 100, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) step(5'b10000, 100, 100, 100, 1'b1, 1'b0);
    // Long random soak.
    for (int c = 0; c < 600; c++)
      step(N'($urandom_range(1, 31)), 75, 50, 65, ($urandom_range(0, 19) != 0), ($urandom_range(0, 199) == 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hybrid_noc_router_output_arbiter.md
Name: hybrid_noc_router_output_arbiter

Overview:
- Per-output-port packet arbiter for the distributed-routing hybrid NoC router.
- Collects the per-port requests (valid bit for this output) from all input-port lookup stages.
- Grants one input at a time, using round-robin, for a whole packet (header to last flit).
- Forwards the granted flits through a single registered output stage to the outgoing link.
- Also has an enable input, used by fault management to isolate the output port at a packet boundary.

Parameters:
- FLIT_WIDTH, 32, flit data width.
- INPUTS, 5, number of input ports that can request this output; must be ≥ 2.
- IDX_WIDTH, $clog2(INPUTS), width of the grant index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_flit  in  INPUTS*FLIT_WIDTH  concatenated flits; input i occupies bits [i*FLIT_WIDTH +: FLIT_WIDTH].
- in_valid  in  INPUTS  request/valid per input (this output's bit of each lookup stage's out_valid).
- in_last  in  INPUTS  last-flit marker per input.
- in_ready  out  INPUTS  ready per input; one-hot or zero.
- out_flit  out  FLIT_WIDTH  registered flit to the link.
- out_valid  out  1  output stage holds a flit.
- out_last  out  1  registered last marker.
- out_ready  in  1  downstream accepts.
- enable  in  1  1 = new packets may be granted; 0 = finish the current packet, then grant nothing.
- grant  out  INPUTS  one-hot current grant (status/debug); zero when IDLE.
- busy  out  1  1 while in ACTIVE or while out_valid = 1.

Behaviour:
- Reset values: out_valid=0, out_last=0, out_flit=0, grant=0, in_ready=0, busy=0. State IDLE. Priority pointer = 0 (input 0 highest).
- FSM states: IDLE and ACTIVE.
- IDLE:
  - If enable=1 and |in_valid, select the first requesting input scanning ptr, ptr+1, …, INPUTS-1, 0, …, ptr-1 (modulo INPUTS).
  - Register that selection as grant and move to ACTIVE.
  - in_ready = 0 throughout IDLE, so arbitration costs one cycle.
- ACTIVE:
  - can_update = ~out_valid | out_ready.
  - in_ready[g] = can_update; all other in_ready bits = 0.
  - Transfer when in_valid[g] & in_ready[g]: out_flit/out_last ← in_flit[g]/in_last[g], out_valid ← 1.
  - Otherwise, when out_ready=1, out_valid ← 0.
  - On a transfer with in_last[g]=1: state ← IDLE, grant ← 0, ptr ← (g+1) mod INPUTS, with explicit wrap at INPUTS-1 → 0.
- Latency:
  - Header at input in cycle t (all idle) → grant registered at t+1 → header accepted at t+1 → out_valid=1 at t+2.
  - Within a packet: one flit per cycle when out_ready is held at 1.
  - Between back-to-back packets: exactly one bubble (the arbitration cycle).
- Handshake rules:
  - out_flit/out_last are stable while out_valid=1 & out_ready=0.
  - out_valid is never dropped without out_ready.
  - Simultaneous read and write of the output stage in the same cycle is allowed (full throughput).
- Boundary conditions:
  - Granted input drops in_valid mid-packet: hold grant, wait indefinitely; other requesters stay blocked (wormhole).
  - Non-granted in_valid changes: ignored until the next IDLE arbitration.
  - enable falls mid-packet: the current packet completes normally, then stay IDLE until enable=1. Buffered output flit still drains.
  - enable=0 in IDLE: no grant regardless of requests.
  - Single-flit packet (header with last): ACTIVE lasts one transfer cycle.
  - Sole requester: re-granted every packet (pointer rotation does not starve it).
  - Reset mid-packet: state, pointer and output stage clear next cycle; partial packet lost (upstream is reset together).
- Arithmetic: pointer and index are IDX_WIDTH bits; increment uses compare-and-wrap, not power-of-two truncation. Only values < INPUTS are reachable.

Test Plan:
- INPUTS=5, rst released; in_valid=5'b00100 with a 3-flit packet A0..A2, out_ready=1 → grant=5'b00100 the cycle after the request. out_flit=A0 at t+2, A1 at t+3, A2 (out_last=1) at t+4. ptr=3 afterwards.
- All five inputs request 1-flit packets continuously, ptr=0 → grant order 0,1,2,3,4,0. Each packet is separated by one idle arbitration cycle; no input is granted twice before the others.
- Backpressure: out_ready=0 for 4 cycles during a 4-flit packet → out_flit holds its value, in_ready[g]=0 while the stage is full, no flit lost or duplicated. Output sequence is exactly F0..F3.
- Granted input 1 stalls in_valid for 3 cycles mid-packet while input 3 requests → grant stays 5'b00010 until input 1's last flit. Input 3 is granted next.
- enable pulled to 0 on the second flit of a 3-flit packet → packet completes, then a pending request on input 4 stays ungranted (busy=0 once drained). After enable=1, input 4 is granted next cycle.
- rst asserted mid-packet with out_valid=1 → next cycle out_valid=0, grant=0, in_ready=0. First grant after reset goes to the lowest-index requester.
